// File: rtl/tmc_spi_board_router.sv
// Shares one SPI master among four temperature boards. It routes SCLK, MOSI and MISO to the selected board,
// inserts a guard delay before a chip select, and blocks selects to boards that are not present.
module tmc_spi_board_router #(
  parameter int GUARD_CYCLES    = 4,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] m_csn,
  input  logic        m_sclk,
  input  logic        m_mosi,
  output logic        m_miso,
  input  logic [3:0]  live,
  input  logic [3:0]  b_miso,
  output logic [3:0]  b_sclk,
  output logic [3:0]  b_mosi,
  output logic [11:0] b_csn,
  output logic [3:0]  live_ok,
  output logic        err_multi,
  output logic        err_dead,
  input  logic        err_clr,
  output logic [15:0] xfer_cnt
);

  localparam logic [7:0]  GUARD_MAX = 8'(GUARD_CYCLES - 1);
  localparam logic [15:0] DB_MAX    = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GUARD, ACTIVE, BLOCK} state_t;

  state_t      state;
  logic [3:0]  live_s1;
  logic [3:0]  live_s2;
  logic [15:0] db_cnt [4];
  logic [11:0] csn_lat;
  logic [1:0]  brd;
  logic [7:0]  guard_cnt;

  logic [3:0]  low_cnt;
  logic [3:0]  sel_idx;
  logic [1:0]  sel_board;
  logic        one_low;
  logic        multi_low;
  logic        none_low;

  function automatic logic [1:0] board_of(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2:   board_of = 2'd0;
      4'd3, 4'd4, 4'd5:   board_of = 2'd1;
      4'd6, 4'd7, 4'd8:   board_of = 2'd2;
      4'd9, 4'd10, 4'd11: board_of = 2'd3;
      default:            board_of = 2'd0;
    endcase
  endfunction

  // Count the active selects and locate the (last) asserted one
  always_comb begin
    low_cnt = 4'd0;
    sel_idx = 4'd0;
    for (int k = 0; k < 12; k++) begin
      if (!m_csn[k]) begin
        low_cnt = low_cnt + 4'd1;
        sel_idx = 4'(k);
      end else begin
        low_cnt = low_cnt;
      end
    end
    sel_board = board_of(sel_idx);
    one_low   = (low_cnt == 4'd1);
    multi_low = (low_cnt > 4'd1);
    none_low  = (m_csn == 12'hFFF);
  end

  // Synchronize the board-present inputs and debounce them per bit
  always_ff @(posedge clk) begin
    if (rst) begin
      live_s1 <= 4'h0;
      live_s2 <= 4'h0;
      live_ok <= 4'h0;
      for (int b = 0; b < 4; b++) db_cnt[b] <= 16'd0;
    end else begin
      live_s1 <= live;
      live_s2 <= live_s1;
      for (int b = 0; b < 4; b++) begin
        if (live_s2[b] != live_ok[b]) begin
          if (db_cnt[b] == DB_MAX) begin
            live_ok[b] <= live_s2[b];
            db_cnt[b]  <= 16'd0;
          end else begin
            db_cnt[b] <= db_cnt[b] + 16'd1;
          end
        end else begin
          db_cnt[b] <= 16'd0;
        end
      end
    end
  end

  // Routing FSM with registered board/master outputs, sticky errors and transfer count
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      csn_lat   <= 12'hFFF;
      brd       <= 2'd0;
      guard_cnt <= 8'd0;
      b_csn     <= 12'hFFF;
      b_sclk    <= 4'h0;
      b_mosi    <= 4'h0;
      m_miso    <= 1'b0;
      err_multi <= 1'b0;
      err_dead  <= 1'b0;
      xfer_cnt  <= 16'd0;
    end else begin
      // Later error sets in this block override the clear, so a set wins
      if (err_clr) begin
        err_multi <= 1'b0;
        err_dead  <= 1'b0;
      end else begin
        err_multi <= err_multi;
      end
      b_sclk <= 4'h0;
      b_mosi <= 4'h0;
      m_miso <= 1'b0;
      case (state)
        IDLE: begin
          b_csn <= 12'hFFF;
          if (multi_low) begin
            state     <= BLOCK;
            err_multi <= 1'b1;
          end else if (one_low) begin
            csn_lat   <= m_csn;
            brd       <= sel_board;
            guard_cnt <= 8'd0;
            if (live_ok[sel_board]) begin
              state <= GUARD;
            end else begin
              state    <= BLOCK;
              err_dead <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        GUARD: begin
          if (m_csn != csn_lat) begin
            state <= IDLE;
            b_csn <= 12'hFFF;
          end else if (guard_cnt == GUARD_MAX) begin
            state       <= ACTIVE;
            b_csn       <= csn_lat;
            b_sclk[brd] <= m_sclk;
            b_mosi[brd] <= m_mosi;
            m_miso      <= b_miso[brd];
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
            b_csn     <= 12'hFFF;
          end
        end
        ACTIVE: begin
          if (none_low) begin
            state    <= IDLE;
            b_csn    <= 12'hFFF;
            xfer_cnt <= xfer_cnt + 16'd1;
          end else if (m_csn != csn_lat) begin
            state     <= BLOCK;
            b_csn     <= 12'hFFF;
            err_multi <= 1'b1;
          end else if (!live_ok[brd]) begin
            state    <= BLOCK;
            b_csn    <= 12'hFFF;
            err_dead <= 1'b1;
          end else begin
            b_csn       <= csn_lat;
            b_sclk[brd] <= m_sclk;
            b_mosi[brd] <= m_mosi;
            m_miso      <= b_miso[brd];
          end
        end
        BLOCK: begin
          b_csn <= 12'hFFF;
          if (none_low) state <= IDLE;
          else          state <= BLOCK;
        end
        default: begin
          state <= IDLE;
          b_csn <= 12'hFFF;
        end
      endcase
    end
  end

endmodule
